// File: rtl/instruction_fetch.sv
// RV64 fetch front end: owns the PC, issues single-outstanding word fetches, holds one instruction for decode.
// Latency: request in REQ, response no earlier than next cycle, instruction visible the cycle after the response.
// Backpressure: stall holds the slot and blocks new requests; a pending response is always accepted.
module instruction_fetch #(
    parameter int                     ADDRSIZE  = 64,
    parameter int                     INSTRSIZE = 32,
    parameter logic [ADDRSIZE-1:0]    RESET_PC  = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [ADDRSIZE-1:0]       imem_req_addr,
    input  logic                      imem_resp_valid,
    input  logic [INSTRSIZE-1:0]      imem_resp_data,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [ADDRSIZE-1:0]       branch_pc,
    input  logic [ADDRSIZE-1:0]       branch_imm,
    output logic                      instr_valid,
    output logic [INSTRSIZE-1:0]      instruction,
    output logic [ADDRSIZE-1:0]       instr_pc,
    output logic                      fetch_misaligned
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDRSIZE-1:0]    pc_q, pc_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [INSTRSIZE-1:0]   instruction_q, instruction_d;
    logic [ADDRSIZE-1:0]    instr_pc_q, instr_pc_d;
    logic                   misaligned_q, misaligned_d;

    logic                   slot_free;
    logic                   req_fire;
    logic [ADDRSIZE-1:0]    target;

    assign slot_free = !instr_valid_q || !stall;
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign target    = branch_pc + branch_imm;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end else if (branch_taken) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // The stale response is dropped whether or not a new redirect arrives with it.
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_valid = !reset && (state_q == S_REQ) && slot_free && !branch_taken;
        imem_req_addr  = pc_q;
    end

    // Datapath next state: redirect wins over stall and any same-cycle response
    always_comb begin
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q && stall;
        instruction_d = instruction_q;
        instr_pc_d    = instr_pc_q;
        misaligned_d  = 1'b0;
        if (branch_taken) begin
            pc_d          = {target[ADDRSIZE-1:2], 2'b00};
            misaligned_d  = |target[1:0];
            instr_valid_d = 1'b0;
        end else if ((state_q == S_WAIT) && imem_resp_valid) begin
            instruction_d = imem_resp_data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + ADDRSIZE'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instruction_q <= '0;
            instr_pc_q    <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instruction_q <= instruction_d;
            instr_pc_q    <= instr_pc_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign instr_valid      = instr_valid_q;
    assign instruction      = instruction_q;
    assign instr_pc         = instr_pc_q;
    assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural memory, expected-fetch-address queue and instruction scoreboard.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_pc;
    logic [63:0] branch_imm;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [63:0] instr_pc;
    logic        fetch_misaligned;

    instruction_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_pc        (branch_pc),
        .branch_imm       (branch_imm),
        .instr_valid      (instr_valid),
        .instruction      (instruction),
        .instr_pc         (instr_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Inputs for the next cycle, applied just after the rising edge
    logic        n_reset, n_stall, n_br, n_rdy;
    logic [63:0] n_bpc, n_bimm;

    // Memory model state
    logic        mem_pending, mem_wrong, mem_const, resp_wrong;
    logic [63:0] mem_addr, resp_pc;
    int          mem_wait, mem_lat;

    logic [63:0] exp_addr[$];
    logic [95:0] sb[$];
    int          hs_cnt = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(logic [63:0] a);
        if (mem_const) return 32'h0000_0013;
        return a[31:0] ^ 32'hA5A5_0003;
    endfunction

    task automatic tick();
        logic [95:0] item;
        @(posedge clk);
        #1;
        reset          = n_reset;
        stall          = n_stall;
        branch_taken   = n_br;
        branch_pc      = n_bpc;
        branch_imm     = n_bimm;
        imem_req_ready = n_rdy;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'hDEAD_BEEF;
        if (n_reset) begin
            mem_pending = 1'b0;
        end else if (mem_pending && mem_wait == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(mem_addr);
            resp_pc         = mem_addr;
            resp_wrong      = mem_wrong;
            mem_pending     = 1'b0;
        end else if (mem_pending) begin
            mem_wait--;
        end
        #1;
        if (reset) begin
            sb.delete();
        end else begin
            if (instr_valid && !stall) begin
                if (sb.size() == 0) begin
                    check("unexp_instr", {63'd0, instr_valid}, 64'd0);
                end else begin
                    item = sb.pop_front();
                    check("sb_pc", instr_pc, item[95:32]);
                    check("sb_instr", {32'd0, instruction}, {32'd0, item[31:0]});
                end
            end
            if (branch_taken) begin
                sb.delete();
                if (mem_pending) mem_wrong = 1'b1;
            end
            if (imem_resp_valid && !branch_taken && !resp_wrong) begin
                sb.push_back({resp_pc, imem_resp_data});
            end
            if (imem_req_valid && imem_req_ready) begin
                hs_cnt++;
                if (exp_addr.size() == 0) check("unexp_req", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                else check("req_addr", imem_req_addr, exp_addr.pop_front());
                mem_pending = 1'b1;
                mem_addr    = imem_req_addr;
                mem_wait    = mem_lat;
                mem_wrong   = 1'b0;
            end
        end
    endtask

    initial begin
        int nvalid;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_pc = '0; branch_imm = '0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
        n_reset = 1'b1; n_stall = 1'b0; n_br = 1'b0; n_rdy = 1'b1; n_bpc = '0; n_bimm = '0;
        mem_pending = 1'b0; mem_wrong = 1'b0; mem_const = 1'b1; resp_wrong = 1'b0;
        mem_addr = '0; resp_pc = '0; mem_wait = 0; mem_lat = 0;

        tick(); tick();
        check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        check("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_instruction", {32'd0, instruction}, 64'd0);
        check("rst_instr_pc", instr_pc, 64'd0);
        check("rst_misaligned", {63'd0, fetch_misaligned}, 64'd0);

        // Zero-wait memory streaming 0x13
        exp_addr.push_back(64'h0); exp_addr.push_back(64'h4);
        exp_addr.push_back(64'h8); exp_addr.push_back(64'hC);
        n_reset = 1'b0;
        tick();
        check("first_req", {63'd0, imem_req_valid}, 64'd1);
        nvalid = 0;
        for (int i = 2; i <= 8; i++) begin
            tick();
            if (instr_valid) nvalid++;
            if (i == 3) check("instr_13", {32'd0, instruction}, 64'h13);
        end
        check("valid_every_2", nvalid, 3);
        check("hs_count_s1", hs_cnt, 4);
        mem_const = 1'b0;

        // Memory not ready: address held
        exp_addr.push_back(64'h10);
        n_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nrdy_valid", {63'd0, imem_req_valid}, 64'd1);
            check("nrdy_addr", imem_req_addr, 64'h10);
        end
        n_rdy = 1'b1;
        tick();
        check("hs_after_rdy", hs_cnt, 5);
        tick();

        // Stall with a full slot
        exp_addr.push_back(64'h14);
        n_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid", {63'd0, instr_valid}, 64'd1);
            check("stall_pc", instr_pc, 64'h10);
            check("stall_instr", {32'd0, instruction}, {32'd0, 32'h10 ^ 32'hA5A5_0003});
            check("stall_noreq", {63'd0, imem_req_valid}, 64'd0);
        end
        n_stall = 1'b0; mem_lat = 2;
        tick();
        check("release_req", {63'd0, imem_req_valid}, 64'd1);
        check("release_addr", imem_req_addr, 64'h14);

        // Redirect while waiting: pending response for 0x14 is dropped
        exp_addr.push_back(64'h24); exp_addr.push_back(64'h28);
        n_br = 1'b1; n_bpc = 64'h2C; n_bimm = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        n_br = 1'b0; mem_lat = 0;
        tick();
        check("discard_noreq", {63'd0, imem_req_valid}, 64'd0);
        check("aligned_nomis", {63'd0, fetch_misaligned}, 64'd0);
        tick();
        check("discard_resp_noreq", {63'd0, imem_req_valid}, 64'd0);
        tick();
        check("redir_req", {63'd0, imem_req_valid}, 64'd1);
        check("redir_addr", imem_req_addr, 64'h24);
        check("redir_slot_empty", {63'd0, instr_valid}, 64'd0);
        tick(); tick();

        // Misaligned redirect coinciding with a response and stall
        exp_addr.push_back(64'h104);
        n_br = 1'b1; n_bpc = 64'h100; n_bimm = 64'h6; n_stall = 1'b1;
        tick();
        n_br = 1'b0; n_stall = 1'b0;
        tick();
        check("mis_pulse", {63'd0, fetch_misaligned}, 64'd1);
        check("mis_slot_empty", {63'd0, instr_valid}, 64'd0);
        check("mis_addr", imem_req_addr, 64'h104);
        tick();
        check("mis_clear", {63'd0, fetch_misaligned}, 64'd0);

        // Redirect from REQ with a full slot
        exp_addr.push_back(64'h210);
        n_br = 1'b1; n_bpc = 64'h200; n_bimm = 64'h10;
        tick();
        check("req_redir_noreq", {63'd0, imem_req_valid}, 64'd0);
        n_br = 1'b0;
        tick();
        check("req_redir_flush", {63'd0, instr_valid}, 64'd0);
        check("req_redir_addr", imem_req_addr, 64'h210);
        tick();

        // PC wrap at the top of the address space, then reset during WAIT
        exp_addr.push_back(64'hFFFF_FFFF_FFFF_FFFC); exp_addr.push_back(64'h0);
        n_br = 1'b1; n_bpc = 64'hFFFF_FFFF_FFFF_FFF0; n_bimm = 64'hC;
        tick();
        n_br = 1'b0;
        tick(); tick(); tick();
        check("wrap_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_addr", imem_req_addr, 64'h0);
        exp_addr.push_back(64'h0); exp_addr.push_back(64'h4); exp_addr.push_back(64'h8);
        n_reset = 1'b1;
        tick();
        check("rst_wait_noreq", {63'd0, imem_req_valid}, 64'd0);
        n_reset = 1'b0;
        tick();
        check("rst_wait_slot", {63'd0, instr_valid}, 64'd0);
        check("rst_wait_req", {63'd0, imem_req_valid}, 64'd1);
        check("rst_wait_addr", imem_req_addr, 64'h0);
        for (int i = 0; i < 4; i++) tick();

        check("addr_q_drained", exp_addr.size(), 0);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
